// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with ihit/dhit handshakes,
// a memory-wait watchdog and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [DATA_W-1:0] imemload,
    input  logic              zero,
    output logic              imemREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              IRWr,
    output logic              PCWr,
    output logic [1:0]        PCsrc,
    output logic              RegWr,
    output logic [DATA_W-1:0] instr,
    output logic [2:0]        state,
    output logic              halt,
    output logic              bus_err,
    output logic [CNT_W-1:0]  instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpHalt  = 6'h3F;
    localparam logic [5:0] FnJr    = 6'h08;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      instr_q, instr_d;
    logic                   halt_q, halt_d;
    logic                   bus_err_q, bus_err_d;
    logic [CNT_W-1:0]       instret_q, instret_d;
    logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic                   wait_tick;
    logic [TIMEOUT_W-1:0]   wait_inc;

    assign opcode   = instr_q[31:26];
    assign funct    = instr_q[5:0];
    assign wait_inc = wait_cnt_q + TIMEOUT_W'(1);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        halt_d    = halt_q;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        imemREN   = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        IRWr      = 1'b0;
        PCWr      = 1'b0;
        PCsrc     = 2'b00;
        RegWr     = 1'b0;
        wait_tick = 1'b0;

        case (state_q)
            StFetch: begin
                imemREN = 1'b1;
                if (ihit) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    instr_d = imemload;
                    state_d = StDecode;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            StDecode: begin
                if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else if (opcode == OpJ || opcode == OpJal) begin
                    PCWr    = 1'b1;
                    PCsrc   = 2'b10;
                    RegWr   = (opcode == OpJal);
                    state_d = StFetch;
                end else if (opcode == OpRtype && funct == FnJr) begin
                    PCWr    = 1'b1;
                    PCsrc   = 2'b11;
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (opcode)
                    OpBeq, OpBne: begin
                        if ((opcode == OpBeq) == zero) begin
                            PCWr  = 1'b1;
                            PCsrc = 2'b01;
                        end
                        state_d = StFetch;
                    end
                    OpLw, OpSw: state_d = StMem;
                    // R-type and ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI
                    OpRtype, 6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F: state_d = StWb;
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                if (opcode == OpLw) begin
                    dREN = 1'b1;
                    if (dhit) state_d = StWb;
                    else      wait_tick = 1'b1;
                end else if (opcode == OpSw) begin
                    dWEN = 1'b1;
                    if (dhit) state_d = StFetch;
                    else      wait_tick = 1'b1;
                end else begin
                    state_d = StFetch;
                end
            end
            StWb: begin
                RegWr   = 1'b1;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        // Fires on the (2^TIMEOUT_W-1)th consecutive wait cycle; a hit that cycle wins.
        if (wait_tick && (&wait_inc)) begin
            state_d   = StHalt;
            bus_err_d = 1'b1;
        end

        if (state_d == StHalt) halt_d = 1'b1;

        if (state_d == StFetch && state_q != StFetch) instret_d = instret_q + CNT_W'(1);

        if (state_d != state_q) wait_cnt_d = '0;
        else if (wait_tick)     wait_cnt_d = wait_inc;
        else                    wait_cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StFetch;
            instr_q    <= '0;
            halt_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            instret_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            halt_q     <= halt_d;
            bus_err_q  <= bus_err_d;
            instret_q  <= instret_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign instr   = instr_q;
    assign state   = state_q;
    assign halt    = halt_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Clocked successor to the combinational control unit, for the multicycle MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with the instruction and data memories via ihit/dhit.
- Adds a parametrised memory-wait watchdog and a retired-instruction counter.
- Sits between the request unit/caches and the datapath registers (IR, PC, register file).

Parameters:
- DATA_W, 32, instruction/word width.
- TIMEOUT_W, 8, width of memory-wait counter; timeout fires at 2^TIMEOUT_W-1 consecutive wait cycles.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory ready; imemload valid this cycle.
- dhit  in  1  data memory ready/complete.
- imemload  in  DATA_W  fetched instruction.
- zero  in  1  ALU zero flag (valid in EXEC).
- imemREN  out  1  instruction read request.
- dREN  out  1  data read request.
- dWEN  out  1  data write request.
- IRWr  out  1  instruction register load strobe.
- PCWr  out  1  PC load strobe.
- PCsrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (JR).
- RegWr  out  1  register file write enable.
- instr  out  DATA_W  latched instruction register copy.
- state  out  3  current state encoding.
- halt  out  1  sticky halt.
- bus_err  out  1  sticky memory-timeout flag.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Clock/reset: one clock, CLK. nRST is asynchronous, active-low.
- Reset values: state=FETCH(0), instr=0, halt=0, bus_err=0, instret=0, wait_cnt=0.
  - Combinational outputs follow state, so imemREN=1 and all other strobes are 0 while in reset.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Decode uses opcode = instr[31:26] and funct = instr[5:0].
- FETCH:
  - imemREN=1.
  - On ihit: IRWr=1, PCWr=1, PCsrc=00, instr<=imemload, next=DECODE.
  - Else stay and increment wait_cnt.
- DECODE:
  - opcode 0x3F: next=HALT.
  - J (0x02): PCWr=1, PCsrc=10, next=FETCH.
  - JAL (0x03): PCWr=1, PCsrc=10, RegWr=1, next=FETCH.
  - R-type with funct 0x08 (JR): PCWr=1, PCsrc=11, next=FETCH.
  - Any other opcode: next=EXEC.
- EXEC:
  - BEQ (0x04) with zero=1, or BNE (0x05) with zero=0: PCWr=1, PCsrc=01. Either way next=FETCH.
  - LW (0x23) or SW (0x2B): next=MEM.
  - R-type, ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI: next=WB.
  - Unrecognised opcode: next=FETCH with no writes.
- MEM:
  - LW: dREN=1 until dhit, then next=WB.
  - SW: dWEN=1 until dhit, then next=FETCH.
  - dREN and dWEN are never both 1.
- WB: RegWr=1 for exactly one cycle, next=FETCH.
- HALT: halt=1. All request/strobe outputs are 0, including imemREN. State holds until nRST.
- Watchdog:
  - wait_cnt clears on every state change.
  - It increments each FETCH/MEM cycle without the awaited hit.
  - When wait_cnt = 2^TIMEOUT_W-1 and still no hit: bus_err<=1, next=HALT.
  - A hit arriving in that same cycle wins: normal transition, no error.
- instret:
  - Increments by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB.
  - Not incremented on transitions into HALT.
  - Wraps modulo 2^CNT_W.
- Reset mid-operation (e.g. MEM with dREN=1): dREN/dWEN drop immediately, without waiting for the clock edge. No partial instret update.
- All strobes are single-cycle except the imemREN/dREN/dWEN requests, which hold until their hit.

Test Plan:
- ADDI 0x20010005, ihit after 2 wait cycles -> FETCH 3 cycles, DECODE, EXEC, WB (RegWr=1 one cycle), back to FETCH; instret=1.
- LW 0x8C220004, dhit on 3rd MEM cycle -> dREN high exactly 3 cycles, then WB RegWr=1; SW 0xAC220004 -> dWEN 3 cycles, no WB, instret=2.
- BEQ 0x10000003 with zero=1 -> EXEC PCWr=1 PCsrc=01; with zero=0 -> PCWr=0; BNE inverse; each takes 3 states.
- J 0x08000010 -> PCWr=1 PCsrc=10 in DECODE, FETCH next; JR (0x03E00008) -> PCsrc=11; JAL -> RegWr=1 PCsrc=10.
- TIMEOUT_W=3, ihit never asserted -> after 7 FETCH cycles bus_err=1, halt=1, imemREN=0, instret=0; repeat with ihit on 7th cycle -> no error, DECODE.
- HALT 0xFC000000 -> halt=1 sticky for 20 cycles with ihit toggling; nRST low mid-MEM -> dREN=0 same cycle, state=0, halt=0, bus_err=0.
